// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Event FIFO: timestamps start/stop token events from the sequencer and queues
// them for a host reader; drops on overflow are flagged and counted.
module tt_um_jleugeri_ttt_event_fifo #(
  parameter int unsigned NUM_PROCESSORS = 10,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIME_BITS      = 8,
  localparam int unsigned PID_W = $clog2(NUM_PROCESSORS),
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned W     = TIME_BITS + PID_W + 2
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic [1:0]           stage,
  input  logic                 evt_valid,
  input  logic [PID_W-1:0]     evt_processor_id,
  input  logic [1:0]           evt_startstop,
  input  logic                 clear,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TIME_BITS-1:0] timestep,
  output logic [CNT_W-1:0]     fill_level,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] STAGE_INPUT = 2'b00;
  localparam logic [1:0] STAGE_SCAN  = 2'b10;

  logic [1:0]           stage_prev_q, stage_prev_d;
  logic [TIME_BITS-1:0] ts_q, ts_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           drop_q, drop_d;
  logic [W-1:0]         mem_q [FIFO_DEPTH];

  logic         accept_c, full_c, pop_c, push_c, drop_c;
  logic [W-1:0] entry_c;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    accept_c = evt_valid && (evt_startstop == 2'b01 || evt_startstop == 2'b10) && !clear;
    full_c   = (fill_q == CNT_W'(FIFO_DEPTH));
    pop_c    = (fill_q != '0) && out_ready && !clear;
    push_c   = accept_c && (!full_c || pop_c);
    drop_c   = accept_c && full_c && !pop_c;
    entry_c  = {ts_q, evt_processor_id, evt_startstop};
  end

  always_comb begin
    stage_prev_d = stage;
    ts_d         = ts_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    if (stage_prev_q == STAGE_SCAN && stage == STAGE_INPUT) ts_d = ts_q + TIME_BITS'(1);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push_c && !pop_c) fill_d = fill_q + CNT_W'(1);
      if (pop_c && !push_c) fill_d = fill_q - CNT_W'(1);
      if (drop_c) begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      stage_prev_q <= STAGE_INPUT;
      ts_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      stage_prev_q <= stage_prev_d;
      ts_q         <= ts_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock_fast) begin
    if (push_c && !reset) mem_q[wr_ptr_q] <= entry_c;
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (fill_q != '0);
  assign timestep   = ts_q;
  assign fill_level = fill_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_fifo.sv
// Bench for the event FIFO: directed vector table, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_tt_um_jleugeri_ttt_event_fifo;

  localparam int PID_W = 4;
  localparam int W     = 14;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      stage;
  logic            evt_valid;
  logic [PID_W-1:0] evt_pid;
  logic [1:0]      evt_ss;
  logic            clear;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [7:0]      timestep;
  logic [3:0]      fill_level;
  logic            overflow;
  logic [7:0]      drop_count;

  tt_um_jleugeri_ttt_event_fifo dut (
    .clock_fast(clk), .reset(rst), .stage(stage), .evt_valid(evt_valid),
    .evt_processor_id(evt_pid), .evt_startstop(evt_ss), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .timestep(timestep), .fill_level(fill_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [W-1:0] mq[$];
  int m_ts, m_prev, m_drop;
  bit m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_prev = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit pop, acc;
    logic [W-1:0] e;
    e   = {8'(m_ts), evt_pid, evt_ss};
    pop = (mq.size() > 0) && out_ready;
    acc = evt_valid && (evt_ss == 2'b01 || evt_ss == 2'b10);
    if (clear) begin
      mq.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    if (m_prev == 2 && stage == 2'b00) m_ts = (m_ts + 1) % 256;
    m_prev = int'(stage);
  endtask

  task automatic model_check();
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("timestep", 32'(timestep), 32'(m_ts));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input logic [1:0] st, input logic ev, input logic [3:0] pid,
                       input logic [1:0] ss, input logic clr, input logic rdy);
    stage = st; evt_valid = ev; evt_pid = pid; evt_ss = ss; clear = clr; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] st; logic ev; logic [3:0] pid; logic [1:0] ss; logic clr; logic rdy;
    int fill; logic valid; logic ovf; int drop; int ts; logic [W-1:0] data;
  } vec_t;

  function automatic vec_t mk(logic [1:0] st, logic ev, logic [3:0] pid, logic [1:0] ss,
                              logic rdy, int fill, int ts, logic [W-1:0] data);
    vec_t v;
    v.st = st; v.ev = ev; v.pid = pid; v.ss = ss; v.clr = 0; v.rdy = rdy;
    v.fill = fill; v.valid = (fill != 0); v.ovf = 0; v.drop = 0; v.ts = ts; v.data = data;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [W-1:0] exp35;
    exp35 = {8'd3, 4'd5, 2'b10};
    vecs[0]  = mk(2'b01, 0, 0, 0, 0, 0, 0, '0);
    vecs[1]  = mk(2'b10, 0, 0, 0, 0, 0, 0, '0);
    vecs[2]  = mk(2'b00, 0, 0, 0, 0, 0, 1, '0);
    vecs[3]  = mk(2'b01, 0, 0, 0, 0, 0, 1, '0);
    vecs[4]  = mk(2'b10, 0, 0, 0, 0, 0, 1, '0);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 0, 2, '0);
    vecs[6]  = mk(2'b01, 0, 0, 0, 0, 0, 2, '0);
    vecs[7]  = mk(2'b10, 0, 0, 0, 0, 0, 2, '0);
    vecs[8]  = mk(2'b00, 0, 0, 0, 0, 0, 3, '0);
    vecs[9]  = mk(2'b00, 1, 5, 2'b10, 0, 1, 3, exp35);
    vecs[10] = mk(2'b00, 1, 3, 2'b11, 0, 1, 3, exp35);
    vecs[11] = mk(2'b00, 1, 2, 2'b00, 0, 1, 3, exp35);
    vecs[12] = mk(2'b00, 0, 0, 0, 1, 0, 3, '0);

    do_reset();
    @(negedge clk);
    chk("reset_fill", 32'(fill_level), 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_ts", 32'(timestep), 0);

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].ev, vecs[i].pid, vecs[i].ss, vecs[i].clr, vecs[i].rdy);
      cycle();
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].fill));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_ts", i), 32'(timestep), 32'(vecs[i].ts));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_drop", i), 32'(drop_count), 32'(vecs[i].drop));
      if (vecs[i].valid) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
    end

    // Overflow: 10 events into depth 8, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, 1, 4'(i), 2'b01, 0, 0);
      cycle();
    end
    drive(2'b00, 0, 0, 0, 0, 0);
    chk("ovf_fill", 32'(fill_level), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_count), 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_id%0d", i), 32'(out_data[5:2]), 32'(i));
      drive(2'b00, 0, 0, 0, 0, 1);
      cycle();
    end
    chk("drained_valid", 32'(out_valid), 0);

    // Full with simultaneous push+pop, then sustained streaming across wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, 1, 4'(i), 2'b10, 0, 0);
      cycle();
    end
    drive(2'b00, 1, 4'd8, 2'b01, 0, 1);
    cycle();
    chk("fullpp_fill", 32'(fill_level), 8);
    chk("fullpp_drop", 32'(drop_count), 0);
    chk("fullpp_head", 32'(out_data[5:2]), 1);
    for (int i = 0; i < 20; i++) begin
      drive(2'(i % 4), 1, 4'(i % 10), 2'b01, 0, 1);
      cycle();
    end
    chk("stream_fill", 32'(fill_level), 8);
    chk("stream_ovf", 32'(overflow), 0);

    // Clear on a full, overflowed FIFO with a concurrent event
    drive(2'b00, 1, 4'd9, 2'b01, 0, 0);
    cycle();
    chk("preclr_ovf", 32'(overflow), 1);
    drive(2'b00, 1, 4'd4, 2'b10, 1, 1);
    cycle();
    chk("clr_fill", 32'(fill_level), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_count), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ts", 32'(timestep), 32'(m_ts));

    // Mid-stream async reset empties queue and zeroes timestep
    drive(2'b10, 1, 4'd1, 2'b01, 0, 0);
    cycle();
    drive(2'b00, 1, 4'd2, 2'b01, 0, 0);
    cycle();
    chk("prerst_fill", 32'(fill_level), 2);
    rst = 1'b1;
    #1;
    chk("rst_async_fill", 32'(fill_level), 0);
    chk("rst_async_valid", 32'(out_valid), 0);
    chk("rst_async_ts", 32'(timestep), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held_fill", 32'(fill_level), 0);
    model_reset();
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0);
    cycle();

    // Drop counter saturation
    for (int i = 0; i < 270; i++) begin
      drive(2'b00, 1, 4'(i % 10), 2'b10, 0, 0);
      cycle();
    end
    chk("drop_sat", 32'(drop_count), 255);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 99) == 0),
            (i < 1500) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_jleugeri_ttt_event_fifo.md
TT_UM_JLEUGERI_TTT_EVENT_FIFO -- requirements
Module: tt_um_jleugeri_ttt_event_fifo

Interface
REQ-001: Parameter NUM_PROCESSORS, default 10, number of processors; PID_W = $clog2(NUM_PROCESSORS).
REQ-002: Parameter FIFO_DEPTH, default 8, event entries; power of two, >= 2; CNT_W = $clog2(FIFO_DEPTH+1).
REQ-003: Parameter TIME_BITS, default 8, timestep counter width; entry width W = TIME_BITS+PID_W+2.
REQ-004: clock_fast  input  1  sole clock; all state on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: stage  input  2  execution stage from the main sequencer (00 input, 01 update, 10 scan, 11 fan-out).
REQ-007: evt_valid  input  1  one-cycle token event strobe from the main sequencer.
REQ-008: evt_processor_id  input  PID_W  processor that started/stopped a token.
REQ-009: evt_startstop  input  2  {start, stop} flags of the event.
REQ-010: clear  input  1  synchronous flush of queue and error state.
REQ-011: out_data  output  W  head entry {timestamp[TIME_BITS], processor_id[PID_W], startstop[2]}, MSB first.
REQ-012: out_valid  output  1  head entry present.
REQ-013: out_ready  input  1  host consumes head this cycle.
REQ-014: timestep  output  TIME_BITS  current timestep count.
REQ-015: fill_level  output  CNT_W  number of stored entries, 0..FIFO_DEPTH.
REQ-016: overflow  output  1  sticky: at least one event dropped.
REQ-017: drop_count  output  8  dropped events, saturating at 255.

Function
REQ-018: Block SHALL register stage each cycle (stage_prev) and increment timestep by 1, modulo 2^TIME_BITS, in any cycle where stage_prev == 10 and stage == 00.
REQ-019: Event SHALL be accepted when evt_valid == 1 and evt_startstop is 01 or 10; 00 or 11 SHALL be ignored and not counted as dropped.
REQ-020: Accepted entry SHALL carry the timestep value present in the acceptance cycle, before any same-cycle increment.
REQ-021: FIFO SHALL be show-ahead: out_valid = (fill_level != 0); out_data SHALL present the oldest entry without a read request.
REQ-022: Pop SHALL occur when out_valid && out_ready; out_ready while empty SHALL have no effect.
REQ-023: Entry accepted at edge N SHALL be visible on out_valid/out_data after edge N (latency 1 cycle) when the FIFO was empty.
REQ-024: Push while fill_level < FIFO_DEPTH SHALL store the entry; fill_level +1 unless a simultaneous pop occurs (then unchanged).
REQ-025: Push while full with simultaneous pop SHALL store the entry, no drop, fill_level stays FIFO_DEPTH.
REQ-026: Push while full without pop SHALL discard the entry, set overflow, increment drop_count saturating at 255; queued contents unchanged.
REQ-027: Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-028: clear SHALL, on the next edge, set fill_level 0, pointers 0, overflow 0, drop_count 0; timestep and stage_prev SHALL be preserved.
REQ-029: clear SHALL take priority over same-cycle push and pop: that event is discarded and not counted, pop has no effect.
REQ-030: out_data contents while out_valid == 0 are don't-care.

Reset
REQ-031: Assertion of reset SHALL immediately (asynchronously) force timestep 0, stage_prev 00, pointers 0, fill_level 0, out_valid 0, overflow 0, drop_count 0.
REQ-032: Reset asserted mid-operation SHALL discard all queued entries; no event SHALL be accepted while reset is high.
REQ-033: Storage array contents need not be reset.

Verification
REQ-034: Reset, then stage 00->01->10->00 twice -> timestep == 2; out_valid == 0.
REQ-035: timestep 3, evt_valid=1, id 5, startstop 10, out_ready 0 -> next cycle out_valid 1, out_data = {8'd3, 4'd5, 2'b10}, fill_level 1.
REQ-036: 10 accepted events (ids 0..9, startstop 01), out_ready 0, FIFO_DEPTH 8 -> fill_level 8, overflow 1, drop_count 2; draining yields ids 0..7 in order, then out_valid 0.
REQ-037: FIFO full, evt_valid with out_ready 1 same cycle -> no drop, fill_level 8, head advances, new entry last; continuous push+pop for 20 cycles across pointer wrap preserves order.
REQ-038: evt_startstop 11 and 00 with evt_valid 1 -> fill_level, overflow, drop_count unchanged.
REQ-039: Full FIFO with overflow set, clear=1 with concurrent evt_valid -> fill_level 0, overflow 0, drop_count 0, out_valid 0, timestep unchanged; mid-stream reset pulse likewise empties FIFO and zeroes timestep.
